// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path: RCU state encoding,
// sync pattern and PID integrity helper.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RCV_SYNC,
    CHK_SYNC,
    RCV_BYTE,
    STORE,
    EOP_WAIT,
    ERR_WAIT
  } rcu_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // A PID carries its own check nibble: upper half is the complement of the lower.
  function automatic logic pid_valid(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_rcu.sv
// USB RX control unit: sequences sync check, per-byte FIFO writes and EOP/error recovery.
// Outputs registered (write strobe one cycle after byte_received); no backpressure. Option: USB_RX_PID_CHECK_EN.
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             w_enable,
  output logic             r_error,
  output logic             pkt_done,
  output logic [CNT_W-1:0] byte_count
);

  rcu_state_t       state, next_state;
  logic             partial;
  logic             eop_seen;
  logic [7:0]       sync_q;
  logic [CNT_W-1:0] count_inc;
  logic             pid_bad;

  assign count_inc = byte_count + 1'b1;

`ifdef USB_RX_PID_CHECK_EN
  assign pid_bad = (byte_count == '0) && !pid_valid(rcv_data);
`else
  assign pid_bad = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (d_edge) next_state = RCV_SYNC;
      RCV_SYNC: begin
        if (byte_received)  next_state = CHK_SYNC;
        else if (eop)       next_state = ERR_WAIT;
      end
      CHK_SYNC: next_state = (sync_q == SYNC_BYTE) ? RCV_BYTE : ERR_WAIT;
      RCV_BYTE: begin
        if (byte_received)  next_state = STORE;
        else if (eop)       next_state = partial ? ERR_WAIT : EOP_WAIT;
      end
      // The overflowing (or bad-PID) byte is still written on the way out.
      STORE: begin
        if ((count_inc == CNT_W'(MAX_BYTES)) || pid_bad) next_state = ERR_WAIT;
        else                                             next_state = RCV_BYTE;
      end
      EOP_WAIT: if (!eop && d_edge) next_state = IDLE;
      ERR_WAIT: if (eop_seen && !eop && d_edge) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rcving     <= 1'b0;
      w_enable   <= 1'b0;
      r_error    <= 1'b0;
      pkt_done   <= 1'b0;
      byte_count <= '0;
      partial    <= 1'b0;
      eop_seen   <= 1'b0;
      sync_q     <= '0;
    end else begin
      state    <= next_state;
      rcving   <= (next_state != IDLE);
      w_enable <= (next_state == STORE);
      pkt_done <= (state == EOP_WAIT) && (next_state == IDLE);
      // Error recovery needs a full EOP: remember that eop has been high since entering ERR_WAIT.
      eop_seen <= (next_state == ERR_WAIT) && (eop_seen || eop);
      if (state == RCV_SYNC && byte_received) sync_q <= rcv_data;
      if (state == IDLE && d_edge) begin
        r_error    <= 1'b0;
        byte_count <= '0;
        partial    <= 1'b0;
      end else begin
        if (next_state == ERR_WAIT) r_error <= 1'b1;
        if (state == STORE) byte_count <= count_inc;
        if (state inside {CHK_SYNC, RCV_BYTE, STORE}) begin
          if (byte_received)     partial <= 1'b0;
          else if (shift_enable) partial <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Bench for usb_rx_rcu: packet-level reference model plus directed timing checks and random packets.
module tb_usb_rx_rcu;
  import usb_rx_pkg::*;

  localparam int MAXB = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic rcving, w_enable, r_error, pkt_done;
  logic [CW-1:0] byte_count;

  int checks = 0, failures = 0, writes = 0, dones = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  usb_rx_rcu #(.MAX_BYTES(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received), .rcv_data(rcv_data),
    .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .pkt_done(pkt_done), .byte_count(byte_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every FIFO write must deliver the next byte the model says gets stored.
  always @(negedge clk) begin
    if (w_enable === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: data=%02h expected no write", rcv_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rcv_data !== exp_b) begin
          failures++;
          $display("FAIL write_data: got %02h expected %02h", rcv_data, exp_b);
        end
      end
    end
    if (pkt_done === 1'b1) dones++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    d_edge = 1'b0; shift_enable = 1'b0; byte_received = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) begin
      shift_enable = 1'b1; step(); step();
    end
    rcv_data = v; byte_received = 1'b1; step();
    repeat (gap) step();
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1; step(); step();
    end
  endtask

  task automatic finish_line();
    eop = 1'b1; repeat (4) step();
    eop = 1'b0; d_edge = 1'b1; step();
  endtask

  // Packet outcome from the protocol rules alone.
  function automatic void model(input logic [7:0] sync, input int n, input logic [7:0] b[8],
                                input int part, output int stored, output bit err);
    stored = 0; err = 0;
    if (sync != SYNC_BYTE) begin err = 1; return; end
    stored = (n < MAXB) ? n : MAXB;
    if (n >= MAXB) err = 1;
`ifdef USB_RX_PID_CHECK_EN
    if (n >= 1 && !pid_valid(b[0])) begin stored = 1; err = 1; end
`endif
    if (!err && part > 0) err = 1;
  endfunction

  task automatic run_pkt(input logic [7:0] sync, input int n, input logic [7:0] b[8],
                         input int part, output int stored, output bit err);
    int w0, d0;
    model(sync, n, b, part, stored, err);
    for (int i = 0; i < stored; i++) exp_q.push_back(b[i]);
    w0 = writes; d0 = dones;
    d_edge = 1'b1; step();
    chk("rcving_start", rcving, 1);
    chk("r_error_cleared", r_error, 0);
    step();
    send_byte(sync, 3);
    for (int k = 0; k < n; k++) send_byte(b[k], 3);
    shifts(part);
    finish_line();
    chk("pkt_done", pkt_done, int'(!err));
    chk("rcving_end", rcving, 0);
    chk("r_error", r_error, int'(err));
    chk("byte_count", byte_count, stored);
    step();
    chk("pkt_done_width", pkt_done, 0);
    chk("writes_per_pkt", writes - w0, stored);
    chk("dones_per_pkt", dones - d0, int'(!err));
    exp_q.delete();
    repeat (3) step();
  endtask

  initial begin
    logic [7:0] b[8];
    int stored, part, n, w0;
    bit err;
    logic [7:0] s;

    repeat (3) step();
    chk("rst_rcving", rcving, 0);
    chk("rst_w_enable", w_enable, 0);
    chk("rst_r_error", r_error, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_byte_count", byte_count, 0);
    rst = 1'b0; step();

    // Good packet of three bytes.
    b = '{8'hC3, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt(8'h80, 3, b, 0, stored, err);
    chk("pin_good_stored", stored, 3);
    chk("pin_good_err", int'(err), 0);

    // Bad sync: error flagged two cycles after byte_received, no writes.
    w0 = writes;
    d_edge = 1'b1; step(); step();
    send_byte(8'h81, 0);
    chk("badsync_chk_cycle", r_error, 0);
    step();
    chk("badsync_err_n2", r_error, 1);
    send_byte(8'hC3, 3);
    finish_line();
    chk("badsync_rcving", rcving, 0);
    chk("badsync_pkt_done", pkt_done, 0);
    step();
    chk("badsync_err_sticky", r_error, 1);
    chk("badsync_writes", writes - w0, 0);
    repeat (3) step();
    run_pkt(8'h80, 3, b, 0, stored, err);

    // Misaligned EOP after one byte; write strobe exactly at n+1.
    w0 = writes;
    exp_q.push_back(8'h5A);
    d_edge = 1'b1; step(); step();
    send_byte(8'h80, 3);
    send_byte(8'h5A, 0);
    chk("w_enable_n1", w_enable, 1);
    step();
    chk("w_enable_single", w_enable, 0);
    step();
    shifts(3);
    finish_line();
    chk("misalign_err", r_error, 1);
    chk("misalign_done", pkt_done, 0);
    step();
    chk("misalign_writes", writes - w0, 1);
    repeat (3) step();

    // Overflow and empty packet.
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
    run_pkt(8'h80, 5, b, 0, stored, err);
    chk("pin_ovf_stored", stored, 4);
    chk("pin_ovf_err", int'(err), 1);
    run_pkt(8'h80, 0, b, 0, stored, err);
    chk("pin_empty_err", int'(err), 0);

`ifdef USB_RX_PID_CHECK_EN
    b = '{8'hA4, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt(8'h80, 2, b, 0, stored, err);
    chk("pin_badpid_stored", stored, 1);
    b = '{8'h5A, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt(8'h80, 2, b, 0, stored, err);
    chk("pin_goodpid_err", int'(err), 0);
`endif

    // Reset coinciding with byte_received in RCV_BYTE must suppress the write.
    d_edge = 1'b1; step(); step();
    send_byte(8'h80, 3);
    shifts(8);
    rcv_data = 8'h77; byte_received = 1'b1; rst = 1'b1; step();
    chk("rstmid_w_enable", w_enable, 0);
    chk("rstmid_rcving", rcving, 0);
    chk("rstmid_r_error", r_error, 0);
    chk("rstmid_pkt_done", pkt_done, 0);
    chk("rstmid_byte_count", byte_count, 0);
    rst = 1'b0;
    repeat (4) step();
    chk("rstmid_no_late_write", w_enable, 0);

    for (int t = 0; t < 40; t++) begin
      s = 8'h80;
      if ($urandom_range(0, 5) == 0) begin
        s = 8'($urandom);
        if (s == 8'h80) s = 8'h81;
      end
      n = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) b[0] = {~b[0][3:0], b[0][3:0]};
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_pkt(s, n, b, part, stored, err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
